// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and helpers for the load/store unit
package load_store_unit_pkg;

    typedef logic [31:0] cpu_word;

    typedef enum logic [1:0] {
        MEM_B       = 2'b00,
        MEM_H       = 2'b01,
        MEM_W       = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic {
        LSU_IDLE   = 1'b0,
        LSU_SECOND = 1'b1
    } lsu_state_e;

    localparam int unsigned DEFAULT_MEM_BYTES = 131072;

    // Illegal size reports 4 so range math stays sane; it faults anyway.
    function automatic logic [2:0] size_bytes(input mem_size_e size);
        case (size)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and RAM port 2 bundle
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic      req_valid;
    logic      req_is_store;
    mem_size_e req_size;
    logic      req_signed;
    cpu_word   req_addr;
    cpu_word   req_wdata;
    logic      req_ready;
    logic      resp_valid;
    cpu_word   resp_rdata;
    logic      resp_fault;
    cpu_word   mem_addr;
    logic      mem_is_store;
    cpu_word   mem_wdata;
    cpu_word   mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_addr, mem_is_store, mem_wdata
    );

    modport master (
        output req_valid, req_is_store, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_addr, mem_is_store, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_byte_lane_merge.sv
// rtl/load_store_unit_byte_lane_merge.sv - byte-lane extract/extend or insert by offset and count
module load_store_unit_byte_lane_merge
    import load_store_unit_pkg::*;
#(
    parameter bit INSERT = 1'b0
) (
    input  cpu_word    word,
    input  cpu_word    data,
    input  logic [1:0] offset,
    input  logic [2:0] count,
    input  logic       sign_ext,
    output cpu_word    result
);

    cpu_word shifted_word;
    cpu_word shifted_data;
    cpu_word extracted;
    cpu_word merged;
    logic    sign_bit;

    always_comb begin
        shifted_word = word >> {offset, 3'b000};
        shifted_data = data << {offset, 3'b000};
        sign_bit     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == int'(count) - 1) begin
                sign_bit = shifted_word[8*i+7];
            end
        end
        // Lanes past byte 3 fall off; the caller covers them with a second access.
        for (int i = 0; i < 4; i++) begin
            extracted[8*i +: 8] = (i < int'(count)) ? shifted_word[8*i +: 8]
                                                    : {8{sign_ext & sign_bit}};
            merged[8*i +: 8]    = (i >= int'(offset) && i < int'(offset) + int'(count))
                                  ? shifted_data[8*i +: 8] : word[8*i +: 8];
        end
        result = INSERT ? merged : extracted;
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word access to a word RAM with split unaligned accesses
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    lsu_state_e state;
    cpu_word    lo_bytes;

    logic [1:0]  offset;
    logic [2:0]  nbytes;
    logic [2:0]  lo_cnt;
    logic [2:0]  hi_cnt;
    logic        crossing;
    logic        fault;
    logic [32:0] end_addr;
    cpu_word     word_a;
    cpu_word     combined;
    cpu_word     load_word;
    cpu_word     load_result;
    cpu_word     store_data;
    logic [1:0]  store_off;
    logic [2:0]  store_cnt;
    logic        in_second;

    assign in_second = (state == LSU_SECOND);
    assign offset    = bus.req_addr[1:0];
    assign nbytes    = size_bytes(bus.req_size);
    assign crossing  = ({1'b0, offset} + nbytes) > 3'd4;
    assign lo_cnt    = 3'd4 - {1'b0, offset};
    assign hi_cnt    = {1'b0, offset} + nbytes - 3'd4;
    assign word_a    = {bus.req_addr[31:2], 2'b00};

    // 33-bit sum so an access wrapping past the top of the address space faults.
    assign end_addr = {1'b0, bus.req_addr} + 33'(nbytes) - 33'd1;
    assign fault    = (bus.req_size == MEM_ILLEGAL) || (end_addr >= 33'(MEM_BYTES));

    // Second half of a split load: latched low bytes sit below the new word's bytes.
    assign combined  = lo_bytes | (bus.mem_rdata << {lo_cnt, 3'b000});
    assign load_word = in_second ? combined : bus.mem_rdata;

    load_store_unit_byte_lane_merge #(.INSERT(1'b0)) u_load_extract (
        .word     (load_word),
        .data     ('0),
        .offset   (in_second ? 2'd0 : offset),
        .count    (nbytes),
        .sign_ext (bus.req_signed),
        .result   (load_result)
    );

    assign store_data = in_second ? (bus.req_wdata >> {lo_cnt, 3'b000}) : bus.req_wdata;
    assign store_off  = in_second ? 2'd0 : offset;
    assign store_cnt  = in_second ? hi_cnt : nbytes;

    load_store_unit_byte_lane_merge #(.INSERT(1'b1)) u_store_merge (
        .word     (bus.mem_rdata),
        .data     (store_data),
        .offset   (store_off),
        .count    (store_cnt),
        .sign_ext (1'b0),
        .result   (bus.mem_wdata)
    );

    always_comb begin
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_fault   = 1'b0;
        bus.resp_rdata   = '0;
        bus.mem_addr     = '0;
        bus.mem_is_store = 1'b0;
        if (rst_n) begin
            case (state)
                LSU_IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        if (fault) begin
                            bus.resp_valid = 1'b1;
                            bus.resp_fault = 1'b1;
                        end else begin
                            bus.mem_addr     = word_a;
                            bus.mem_is_store = bus.req_is_store;
                            if (crossing) begin
                                bus.req_ready = 1'b0;
                            end else if (!bus.req_is_store) begin
                                bus.resp_valid = 1'b1;
                                bus.resp_rdata = load_result;
                            end
                        end
                    end
                end
                LSU_SECOND: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        bus.mem_addr     = word_a + 32'd4;
                        bus.mem_is_store = bus.req_is_store;
                        if (!bus.req_is_store) begin
                            bus.resp_valid = 1'b1;
                            bus.resp_rdata = load_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LSU_IDLE;
            lo_bytes <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (bus.req_valid && !fault && crossing) begin
                        state <= LSU_SECOND;
                        if (!bus.req_is_store) begin
                            lo_bytes <= bus.mem_rdata >> {offset, 3'b000};
                        end
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed bench for load_store_unit against a word RAM model
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] ram [0:32767];
    logic        pl_en;
    logic [14:0] pl_idx;
    logic [31:0] pl_data;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(131072)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr[16:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_idx] <= pl_data;
        end else if (bus.mem_is_store) begin
            ram[bus.mem_addr[16:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic drive(input logic valid, input logic store, input mem_size_e size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = valid;
        bus.req_is_store = store;
        bus.req_size     = size;
        bus.req_signed   = sgn;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        pl_en    = 1'b0;
        pl_idx   = '0;
        pl_data  = '0;
        drive(1'b1, 1'b1, MEM_W, 1'b0, 32'h100, 32'h0);

        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_fault", 32'(bus.resp_fault), 32'd0);
        chk("rst_store", 32'(bus.mem_is_store), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);

        drive(1'b0, 1'b0, MEM_W, 1'b0, 32'h0, 32'h0);
        tick();
        preload(15'h40, 32'h44332211);
        preload(15'h41, 32'h88776655);
        preload(15'h7FFF, 32'h12345678);
        rst_n = 1'b1;

        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_valid", 32'(bus.resp_valid), 32'd0);
        chk("idle_addr", bus.mem_addr, 32'h0);
        tick();

        drive(1'b1, 1'b0, MEM_W, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("lw_ready", 32'(bus.req_ready), 32'd1);
        chk("lw_valid", 32'(bus.resp_valid), 32'd1);
        chk("lw_rdata", bus.resp_rdata, 32'h44332211);
        chk("lw_store", 32'(bus.mem_is_store), 32'd0);
        tick();

        drive(1'b1, 1'b0, MEM_H, 1'b1, 32'h106, 32'h0);
        @(negedge clk);
        chk("lh_rdata", bus.resp_rdata, 32'hFFFF8877);
        tick();
        drive(1'b1, 1'b0, MEM_H, 1'b0, 32'h106, 32'h0);
        @(negedge clk);
        chk("lhu_rdata", bus.resp_rdata, 32'h00008877);
        tick();
        drive(1'b1, 1'b0, MEM_B, 1'b1, 32'h103, 32'h0);
        @(negedge clk);
        chk("lb_rdata", bus.resp_rdata, 32'h00000044);
        tick();
        drive(1'b1, 1'b0, MEM_B, 1'b1, 32'h107, 32'h0);
        @(negedge clk);
        chk("lb_neg_rdata", bus.resp_rdata, 32'hFFFFFF88);
        tick();

        drive(1'b1, 1'b0, MEM_W, 1'b0, 32'h102, 32'h0);
        @(negedge clk);
        chk("lwx_c0_ready", 32'(bus.req_ready), 32'd0);
        chk("lwx_c0_valid", 32'(bus.resp_valid), 32'd0);
        chk("lwx_c0_addr", bus.mem_addr, 32'h100);
        tick();
        @(negedge clk);
        chk("lwx_c1_addr", bus.mem_addr, 32'h104);
        chk("lwx_c1_ready", 32'(bus.req_ready), 32'd1);
        chk("lwx_c1_valid", 32'(bus.resp_valid), 32'd1);
        chk("lwx_c1_rdata", bus.resp_rdata, 32'h66554433);
        tick();

        drive(1'b1, 1'b1, MEM_B, 1'b0, 32'h101, 32'h000000EE);
        @(negedge clk);
        chk("sb_ready", 32'(bus.req_ready), 32'd1);
        chk("sb_store", 32'(bus.mem_is_store), 32'd1);
        tick();
        drive(1'b0, 1'b0, MEM_W, 1'b0, 32'h0, 32'h0);
        chk("sb_ram", ram[15'h40], 32'h4433EE11);

        preload(15'h40, 32'h44332211);
        drive(1'b1, 1'b1, MEM_W, 1'b0, 32'h103, 32'hAABBCCDD);
        @(negedge clk);
        chk("swx_c0_ready", 32'(bus.req_ready), 32'd0);
        chk("swx_c0_addr", bus.mem_addr, 32'h100);
        tick();
        chk("swx_ram0", ram[15'h40], 32'hDD332211);
        @(negedge clk);
        chk("swx_c1_ready", 32'(bus.req_ready), 32'd1);
        chk("swx_c1_addr", bus.mem_addr, 32'h104);
        tick();
        drive(1'b0, 1'b0, MEM_W, 1'b0, 32'h0, 32'h0);
        chk("swx_ram1", ram[15'h41], 32'h88AABBCC);

        drive(1'b1, 1'b1, MEM_W, 1'b0, 32'h0001FFFE, 32'hCAFEF00D);
        @(negedge clk);
        chk("flt_fault", 32'(bus.resp_fault), 32'd1);
        chk("flt_ready", 32'(bus.req_ready), 32'd1);
        chk("flt_valid", 32'(bus.resp_valid), 32'd1);
        chk("flt_store", 32'(bus.mem_is_store), 32'd0);
        chk("flt_rdata", bus.resp_rdata, 32'h0);
        tick();
        chk("flt_ram", ram[15'h7FFF], 32'h12345678);

        drive(1'b1, 1'b0, MEM_W, 1'b0, 32'h0001FFFC, 32'h0);
        @(negedge clk);
        chk("top_fault", 32'(bus.resp_fault), 32'd0);
        chk("top_rdata", bus.resp_rdata, 32'h12345678);
        tick();

        drive(1'b1, 1'b0, MEM_ILLEGAL, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("ill_fault", 32'(bus.resp_fault), 32'd1);
        tick();

        drive(1'b1, 1'b0, MEM_H, 1'b0, 32'hFFFFFFFF, 32'h0);
        @(negedge clk);
        chk("wrap_fault", 32'(bus.resp_fault), 32'd1);
        tick();

        drive(1'b1, 1'b0, MEM_W, 1'b0, 32'h102, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_store", 32'(bus.mem_is_store), 32'd0);
        tick();

        preload(15'h41, 32'h88776655);
        drive(1'b1, 1'b1, MEM_W, 1'b0, 32'h103, 32'hAABBCCDD);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rsec_store", 32'(bus.mem_is_store), 32'd0);
        chk("rsec_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("rsec_ram1", ram[15'h41], 32'h88776655);
        drive(1'b0, 1'b0, MEM_W, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 1'b0, MEM_W, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        chk("rsec_idle_addr", bus.mem_addr, 32'h100);
        chk("rsec_idle_ready", 32'(bus.req_ready), 32'd1);
        tick();
        drive(1'b0, 1'b0, MEM_W, 1'b0, 32'h0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
